// File: rtl/alu_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer:
//   - ALU_WIDTH : default operand width
//   - OP_*      : 4-bit opcodes accepted on the command port
//   - alu_state_t : sequencer FSM states
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } alu_state_t;

endpackage : alu_pkg

// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
// Command and result handshakes of the ALU operation sequencer.
//   command side : cmd_valid, cmd_ready, command[3:0], inputA, inputB
//   result side  : res_valid, res_ready, result[2*WIDTH-1:0], error
//   status       : busy
// Modports:
//   master - the agent issuing commands and consuming results
//   slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [3:0]           command;
    logic [WIDTH-1:0]     inputA;
    logic [WIDTH-1:0]     inputB;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 error;
    logic                 busy;

    modport master (
        output cmd_valid, command, inputA, inputB, res_ready,
        input  cmd_ready, res_valid, result, error, busy
    );

    modport slave (
        input  cmd_valid, command, inputA, inputB, res_ready,
        output cmd_ready, res_valid, result, error, busy
    );

endinterface : alu_op_sequencer_if

// File: rtl/alu_op_sequencer_iter_engine.sv
// -----------------------------------------------------------------------------
// alu_iter_engine
// Shared bit-serial core: unsigned shift-add multiply and unsigned restoring
// divide, one bit per cycle while step is high. After WIDTH steps the
// outputs hold the final product / quotient / remainder.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load operands (takes precedence over step)
//   step              advance the algorithm by one bit
//   op_is_mul         1: multiply, 0: divide
//   a, b              operands (a = multiplier / dividend, b = multiplicand / divisor)
//   product           2*WIDTH-bit product
//   quotient          WIDTH-bit quotient
//   remainder         WIDTH-bit remainder
// Both algorithms share one {hi,lo} register pair: multiply shifts it right
// while accumulating into hi, divide shifts it left while building the
// quotient into lo and the partial remainder into hi.
// -----------------------------------------------------------------------------
module alu_iter_engine #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic               op_is_mul,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] b_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;

    // One algorithm step: shift-add for multiply, trial subtract for divide
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        if (op_is_mul) begin
            hi_nxt_s = mul_sum_s[WIDTH:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end else begin
            // Partial remainder is always below 2*b, so bit WIDTH of the
            // difference is a clean "went negative" flag.
            if (!div_diff_s[WIDTH]) begin
                hi_nxt_s = div_diff_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt_s = div_shift_s[WIDTH-1:0];
                lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Operand load on start, one step per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
            b_r  <= {WIDTH{1'b0}};
        end else if (start) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= a;
            b_r  <= b;
        end else if (step) begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end
    end

    assign product   = {hi_r, lo_r};
    assign quotient  = lo_r;
    assign remainder = hi_r;

endmodule : alu_iter_engine

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Sequential front end for the arithmetic datapath. Accepts one command at a
// time, runs it to completion and returns a 2*WIDTH-bit result plus an error
// flag. ADD/SUB finish in one execute cycle; MUL/DIV/MOD use the shared
// iterative engine for WIDTH cycles.
// Ports:
//   clk        clock (rising edge)
//   rst_n      asynchronous active-low reset
//   bus        alu_op_sequencer_if.slave (command / result handshakes, busy)
//   stats_clr  (ALU_SEQ_STATS_EN only) clear the handshake counter
//   op_count   (ALU_SEQ_STATS_EN only) number of result handshakes, wrapping
// Configuration macro: ALU_SEQ_STATS_EN adds the op_count / stats_clr ports.
// Result, error and res_valid are loaded together one cycle after entering
// DONE, so every op reports one cycle after its last compute step.
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
`ifdef ALU_SEQ_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       op_count
`endif
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    alu_state_t           state_r;
    alu_state_t           state_nxt_s;

    logic [3:0]           cmd_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [CW-1:0]        count_r;

    logic [2*WIDTH-1:0]   exec_res_r;
    logic                 exec_err_r;
    logic                 use_engine_r;

    logic                 cmd_ready_r;
    logic                 res_valid_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 error_r;
    logic                 busy_r;

    logic                 cmd_fire_s;
    logic                 res_fire_s;
    logic [WIDTH-1:0]     sum_s;
    logic [WIDTH-1:0]     diff_s;
    logic [2*WIDTH-1:0]   exec_res_s;
    logic                 exec_err_s;
    logic                 to_iter_s;
    logic                 engine_start_s;
    logic                 engine_step_s;
    logic [2*WIDTH-1:0]   product_s;
    logic [WIDTH-1:0]     quotient_s;
    logic [WIDTH-1:0]     remainder_s;
    logic [2*WIDTH-1:0]   engine_res_s;

    // Sign-extend a WIDTH-bit two's complement value to 2*WIDTH bits
    function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // Signed overflow: operands (after negating b for subtract) share a sign
    // that the result does not
    function automatic logic ovf(input logic a_msb, input logic b_msb,
                                 input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

    assign cmd_fire_s = (state_r == IDLE) && cmd_ready_r && bus.cmd_valid;
    assign res_fire_s = (state_r == DONE) && res_valid_r && bus.res_ready;

    // Execute-cycle decode of the latched command
    always_comb begin
        sum_s      = a_r + b_r;
        diff_s     = a_r - b_r;
        exec_res_s = {(2*WIDTH){1'b0}};
        exec_err_s = 1'b0;
        to_iter_s  = 1'b0;
        case (cmd_r)
            OP_ADD: begin
                exec_res_s = sext(sum_s);
                exec_err_s = ovf(a_r[WIDTH-1], b_r[WIDTH-1], sum_s[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                exec_res_s = sext(diff_s);
                exec_err_s = ovf(a_r[WIDTH-1], b_r[WIDTH-1], diff_s[WIDTH-1], 1'b1);
            end
            OP_MUL: begin
                to_iter_s = 1'b1;
            end
            OP_DIV, OP_MOD: begin
                if (b_r == {WIDTH{1'b0}}) begin
                    exec_res_s = {(2*WIDTH){1'b1}};
                    exec_err_s = 1'b1;
                end else begin
                    to_iter_s = 1'b1;
                end
            end
            default: begin
                exec_res_s = {(2*WIDTH){1'b0}};
                exec_err_s = 1'b1;
            end
        endcase
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_fire_s) state_nxt_s = EXEC;
                else            state_nxt_s = IDLE;
            end
            EXEC: begin
                if (to_iter_s) state_nxt_s = ITER;
                else           state_nxt_s = DONE;
            end
            ITER: begin
                if (count_r == LAST) state_nxt_s = DONE;
                else                 state_nxt_s = ITER;
            end
            DONE: begin
                if (res_fire_s) state_nxt_s = IDLE;
                else            state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Command capture on acceptance; later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r <= 4'b0000;
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
        end else if (cmd_fire_s) begin
            cmd_r <= bus.command;
            a_r   <= bus.inputA;
            b_r   <= bus.inputB;
        end
    end

    // Iteration counter: cleared in EXEC, counts engine steps in ITER
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (state_r == ITER && count_r != LAST) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= {CW{1'b0}};
        end
    end

    // Execute-cycle outcome, held until the output registers pick it up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_res_r   <= {(2*WIDTH){1'b0}};
            exec_err_r   <= 1'b0;
            use_engine_r <= 1'b0;
        end else if (state_r == EXEC) begin
            exec_res_r   <= exec_res_s;
            exec_err_r   <= exec_err_s;
            use_engine_r <= to_iter_s;
        end
    end

    assign engine_start_s = (state_r == EXEC) && to_iter_s;
    assign engine_step_s  = (state_r == ITER);

    alu_iter_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (engine_start_s),
        .step      (engine_step_s),
        .op_is_mul (cmd_r == OP_MUL),
        .a         (a_r),
        .b         (b_r),
        .product   (product_s),
        .quotient  (quotient_s),
        .remainder (remainder_s)
    );

    // Select the engine output matching the latched opcode
    always_comb begin
        engine_res_s = {(2*WIDTH){1'b0}};
        case (cmd_r)
            OP_MUL:  engine_res_s = product_s;
            OP_DIV:  engine_res_s = {{WIDTH{1'b0}}, quotient_s};
            OP_MOD:  engine_res_s = {{WIDTH{1'b0}}, remainder_s};
            default: engine_res_s = {(2*WIDTH){1'b0}};
        endcase
    end

    // Registered outputs; result/error only change when a new result is posted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            result_r    <= {(2*WIDTH){1'b0}};
            error_r     <= 1'b0;
        end else begin
            cmd_ready_r <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
            if (state_r == DONE && !res_valid_r) begin
                res_valid_r <= 1'b1;
                result_r    <= use_engine_r ? engine_res_s : exec_res_r;
                error_r     <= use_engine_r ? 1'b0 : exec_err_r;
            end else if (res_fire_s) begin
                res_valid_r <= 1'b0;
            end else begin
                res_valid_r <= res_valid_r;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.result    = result_r;
    assign bus.error     = error_r;
    assign bus.busy      = busy_r;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count_r;

    // Result-handshake counter; clear wins over a coincident handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          op_count_r <= 16'h0000;
        else if (stats_clr)  op_count_r <= 16'h0000;
        else if (res_fire_s) op_count_r <= op_count_r + 16'h0001;
        else                 op_count_r <= op_count_r;
    end

    assign op_count = op_count_r;
`endif

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer: hand-computed vectors for add/sub
// (including signed overflow), multiply, divide, modulo, divide-by-zero,
// illegal opcode, result backpressure and mid-operation reset.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(16)) bus ();

`ifdef ALU_SEQ_STATS_EN
    logic        stats_clr;
    logic [15:0] op_count;
`endif

    alu_op_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stats_clr (stats_clr),
        .op_count  (op_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one command and let it be accepted on the next rising edge;
    // afterwards scramble the inputs to prove they were latched.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        check("cmd_ready_before_issue", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.command   = op;
        bus.inputA    = a;
        bus.inputB    = b;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.command   = 4'b1111;
        bus.inputA    = 16'hDEAD;
        bus.inputB    = 16'h0000;
    endtask

    // Count rising edges after acceptance until res_valid is seen (bounded)
    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!bus.res_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    // Full transaction with res_ready already high
    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp_res,
                         input logic exp_err, input int exp_lat);
        issue(op, a, b);
        wait_result(tag, exp_lat);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_error"}, 32'(bus.error), 32'(exp_err));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.command   = 4'b0000;
        bus.inputA    = 16'h0000;
        bus.inputB    = 16'h0000;
        bus.res_ready = 1'b1;
`ifdef ALU_SEQ_STATS_EN
        stats_clr = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // 1. Add / sub
        do_op("add_6_1", OP_ADD, 16'd6, 16'd1, 32'h0000_0007, 1'b0, 2);
        do_op("sub_6_1", OP_SUB, 16'd6, 16'd1, 32'h0000_0005, 1'b0, 2);
        do_op("sub_neg", OP_SUB, 16'd1, 16'd3, 32'hFFFF_FFFE, 1'b0, 2);

        // 2. Signed overflow
        do_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 32'hFFFF_8000, 1'b1, 2);
        do_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 32'h0000_7FFF, 1'b1, 2);

        // 3. Multiply
        do_op("mul_300_200", OP_MUL, 16'd300, 16'd200, 32'h0000_EA60, 1'b0, 18);
        do_op("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 18);

        // 4. Divide, modulo, divide-by-zero, illegal opcode
        do_op("div_100_7", OP_DIV, 16'd100, 16'd7, 32'h0000_000E, 1'b0, 18);
        do_op("mod_100_7", OP_MOD, 16'd100, 16'd7, 32'h0000_0002, 1'b0, 18);
        do_op("div_max_1", OP_DIV, 16'hFFFF, 16'd1, 32'h0000_FFFF, 1'b0, 18);
        do_op("div_by_0", OP_DIV, 16'd5, 16'd0, 32'hFFFF_FFFF, 1'b1, 2);
        do_op("mod_by_0", OP_MOD, 16'd5, 16'd0, 32'hFFFF_FFFF, 1'b1, 2);
        do_op("illegal", 4'b1111, 16'd9, 16'd9, 32'h0000_0000, 1'b1, 2);

        // 5. Backpressure on the result, with a command offered meanwhile
        bus.res_ready = 1'b0;
        issue(OP_MUL, 16'd3, 16'd4);
        wait_result("mul_3_4", 18);
        bus.cmd_valid = 1'b1;
        bus.command   = OP_ADD;
        bus.inputA    = 16'd1;
        bus.inputB    = 16'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_result", bus.result, 32'h0000_000C);
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        // Result handshake with a command still offered: must not be taken
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("handoff_busy", 32'(bus.busy), 32'd0);
        check("handoff_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("idle_result_hold", bus.result, 32'h0000_000C);
        bus.cmd_valid = 1'b0;

        // 6. Reset during the iterative divide
        issue(OP_DIV, 16'd1000, 16'd3);
        repeat (6) @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        do_op("add_2_2", OP_ADD, 16'd2, 16'd2, 32'h0000_0004, 1'b0, 2);

`ifdef ALU_SEQ_STATS_EN
        check("op_count", 32'(op_count), 32'd1);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        check("op_count_clr", 32'(op_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_op_sequencer
